// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for instr_fetch_unit.
// master: the fetch unit side (drives the imem request, the decoder-facing
//         instruction port and the status outputs).
// slave:  the environment side (instruction memory, decoder, redirect logic).
// Signals:
//   imem_req_valid/imem_req_ready/imem_addr   fetch request channel
//   imem_rsp_valid/imem_rsp_data              fetch response channel
//   inst_valid/inst_ready/instruction/inst_pc/pc_plus4   decoder port
//   redirect_valid/redirect_pc                PC redirect from branch/jump resolution
//   misalign_err/retired_cnt                  status outputs
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;
    logic [31:0] retired_cnt;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output inst_valid,
        input  inst_ready,
        output instruction,
        output inst_pc,
        output pc_plus4,
        input  redirect_valid,
        input  redirect_pc,
        output misalign_err,
        output retired_cnt
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  inst_valid,
        output inst_ready,
        input  instruction,
        input  inst_pc,
        input  pc_plus4,
        output redirect_valid,
        output redirect_pc,
        input  misalign_err,
        input  retired_cnt
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one imem request at a time and
// holds the fetched word on a valid/ready port towards the control decoder.
// Redirects override any state and discard whatever fetch is in flight.
// Ports:
//   clk    clock, all state updates on posedge
//   rst_n  synchronous active-low reset
//   bus    instr_fetch_unit_if.master (imem request/response, decoder port,
//          redirect input, misalign_err pulse, retired_cnt)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    state_t            reset_state_c;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   pc_d;
    logic [XLEN-1:0]   inst_q;
    logic [XLEN-1:0]   inst_pc_q;
    logic [XLEN-1:0]   pc_plus4_q;
    logic [XLEN-1:0]   retired_q;
    logic              misalign_q;
    logic              latch_c;
    logic              retire_c;
    logic              kill_c;
    logic [XLEN-1:0]   redirect_aligned_c;

    assign redirect_aligned_c = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Next-state / PC / strobe logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        latch_c       = 1'b0;
        retire_c      = 1'b0;
        kill_c        = 1'b0;
        // A request still outstanding across reset must have its response swallowed.
        reset_state_c = ((state_q == WAIT) || (state_q == DROP)) && !bus.imem_rsp_valid
                        ? DROP : FETCH;

        unique case (state_q)
            FETCH: begin
                if (bus.imem_req_ready) begin
                    state_d = bus.redirect_valid ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rsp_valid) begin
                    if (bus.redirect_valid) begin
                        state_d = FETCH;
                    end else begin
                        state_d = HOLD;
                        latch_c = 1'b1;
                    end
                end else if (bus.redirect_valid) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    state_d = FETCH;
                    kill_c  = 1'b1;
                end else if (bus.inst_ready) begin
                    state_d  = FETCH;
                    retire_c = 1'b1;
                end
            end
            DROP: begin
                if (bus.imem_rsp_valid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        if (bus.redirect_valid) begin
            pc_d = redirect_aligned_c;
        end else if (retire_c) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // State and PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= reset_state_c;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Decoder-facing buffer, retire counter and misalign pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inst_q     <= NOP_INST;
            inst_pc_q  <= RESET_PC;
            pc_plus4_q <= RESET_PC + XLEN'(4);
            retired_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
            if (latch_c) begin
                inst_q     <= bus.imem_rsp_data;
                inst_pc_q  <= pc_q;
                pc_plus4_q <= pc_q + XLEN'(4);
            end else if (retire_c || kill_c) begin
                inst_q <= NOP_INST;
            end
            if (retire_c) begin
                retired_q <= retired_q + XLEN'(1);
            end
        end
    end

    // Request is suppressed combinationally while reset is asserted.
    assign bus.imem_req_valid = (state_q == FETCH) && rst_n;
    assign bus.imem_addr      = pc_q;
    assign bus.inst_valid     = (state_q == HOLD);
    assign bus.instruction    = inst_q;
    assign bus.inst_pc        = inst_pc_q;
    assign bus.pc_plus4       = pc_plus4_q;
    assign bus.misalign_err   = misalign_q;
    assign bus.retired_cnt    = retired_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level model.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam int unsigned NCYC   = 5000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: pending = request accepted and unanswered; kill = its data is unwanted;
    // have = an instruction is offered to the decoder.
    bit          m_pend, m_kill, m_have, m_mis;
    logic [31:0] m_pc, m_inst, m_ipc, m_p4, m_cnt;

    // Memory: at most one outstanding request, answered after 1..3 cycles.
    bit mem_busy, rsp_real, acc;
    int mem_wait;

    task automatic model_reset();
        m_pend = m_pend && !bus.imem_rsp_valid;
        m_kill = m_pend;
        m_have = 1'b0;
        m_pc   = RST_PC;
        m_inst = NOP;
        m_ipc  = RST_PC;
        m_p4   = RST_PC + 32'd4;
        m_cnt  = 32'd0;
        m_mis  = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] opc;
        bit redir, issue, retire;
        if (!rst_n) begin
            model_reset();
            return;
        end
        opc    = m_pc;
        redir  = bus.redirect_valid;
        issue  = !m_pend && !m_have && bus.imem_req_ready;
        retire = m_have && bus.inst_ready && !redir;
        m_mis  = redir && (bus.redirect_pc[1:0] != 2'b00);
        if (m_pend) begin
            if (bus.imem_rsp_valid) begin
                if (!m_kill && !redir) begin
                    m_have = 1'b1;
                    m_inst = bus.imem_rsp_data;
                    m_ipc  = opc;
                    m_p4   = opc + 32'd4;
                end
                m_pend = 1'b0;
                m_kill = 1'b0;
            end else if (redir) begin
                m_kill = 1'b1;
            end
        end else if (m_have) begin
            if (redir || bus.inst_ready) begin
                m_have = 1'b0;
                m_inst = NOP;
            end
        end else if (issue) begin
            m_pend = 1'b1;
            m_kill = redir;
        end
        if (retire) m_cnt = m_cnt + 32'd1;
        if (redir) m_pc = {bus.redirect_pc[31:2], 2'b00};
        else if (retire) m_pc = opc + 32'd4;
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFFC;
            2:       return 32'h0000_0203;
            default: return $urandom & 32'h0000_03FF;
        endcase
    endfunction

    initial begin
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'd0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        m_pend   = 1'b0;
        m_kill   = 1'b0;
        mem_busy = 1'b0;
        mem_wait = 0;
        model_reset();

        for (int cyc = 0; cyc < int'(NCYC); cyc++) begin
            rst_n              = (cyc < 3 || $urandom_range(99) < 2) ? 1'b0 : 1'b1;
            bus.imem_req_ready = ($urandom_range(9) < 7);
            bus.inst_ready     = ($urandom_range(9) < 6);
            bus.redirect_valid = ($urandom_range(99) < 8);
            bus.redirect_pc    = pick_target();
            bus.imem_rsp_data  = $urandom;
            rsp_real           = 1'b0;
            if (mem_busy && mem_wait == 0) begin
                bus.imem_rsp_valid = 1'b1;
                rsp_real           = 1'b1;
            end else begin
                if (mem_busy) mem_wait--;
                // First cycle pulses a response so an unknown power-up state settles.
                bus.imem_rsp_valid = !mem_busy && (cyc == 0 || $urandom_range(19) == 0);
            end

            @(negedge clk);
            acc = bus.imem_req_valid && bus.imem_req_ready;
            model_step();
            @(posedge clk);
            #1;
            if (rsp_real) mem_busy = 1'b0;
            if (acc) begin
                mem_busy = 1'b1;
                mem_wait = $urandom_range(2);
            end

            if (cyc >= 1) begin
                check_eq("imem_req_valid", 32'(bus.imem_req_valid), 32'(rst_n && !m_pend && !m_have));
                check_eq("imem_addr",      bus.imem_addr,           m_pc);
                check_eq("inst_valid",     32'(bus.inst_valid),     32'(m_have));
                check_eq("instruction",    bus.instruction,         m_inst);
                check_eq("inst_pc",        bus.inst_pc,             m_ipc);
                check_eq("pc_plus4",       bus.pc_plus4,            m_p4);
                check_eq("misalign_err",   32'(bus.misalign_err),   32'(m_mis));
                check_eq("retired_cnt",    bus.retired_cnt,         m_cnt);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
